// File: rtl/alu.sv
// Execute-stage 32-bit integer ALU: operand-B mux, arithmetic/logic/shift/compare ops,
// zero and carry/borrow flags, with an optional single output register stage.
module alu #(
   parameter bit REG_OUT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        aluSrc,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic [31:0] imm,
   input  logic [3:0]  aluCtrl,
   output logic [31:0] result,
   output logic        zero,
   output logic        overflow
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_XOR  = 4'b0001,
      OP_SUB  = 4'b0010,
      OP_SLTU = 4'b0011,
      OP_AND  = 4'b0100,
      OP_OR   = 4'b0101,
      OP_SLL  = 4'b0110,
      OP_SRL  = 4'b0111,
      OP_SLT  = 4'b1000,
      OP_BEQ  = 4'b1001,
      OP_BNE  = 4'b1010,
      OP_SRA  = 4'b1011
   } alu_op_e;

   logic [31:0] opb;
   logic [32:0] sum;
   logic [32:0] diff;
   logic        lt_u;
   logic        lt_s;
   logic [4:0]  shamt;
   logic [31:0] res_c;
   logic        ovf_c;

   assign opb   = aluSrc ? imm : data2;
   assign sum   = {1'b0, data1} + {1'b0, opb};
   assign diff  = {1'b0, data1} - {1'b0, opb};
   assign lt_u  = diff[32];
   // Signed less-than: differing signs decide directly, otherwise the unsigned borrow does.
   assign lt_s  = (data1[31] != opb[31]) ? data1[31] : diff[32];
   assign shamt = opb[4:0];

   always_comb begin
      res_c = 32'd0;
      ovf_c = 1'b0;
      case (aluCtrl)
         OP_ADD:  begin res_c = sum[31:0];  ovf_c = sum[32]; end
         OP_XOR:  res_c = data1 ^ opb;
         OP_SUB:  begin res_c = diff[31:0]; ovf_c = lt_u; end
         OP_SLTU: res_c = {31'd0, lt_u};
         OP_AND:  res_c = data1 & opb;
         OP_OR:   res_c = data1 | opb;
         OP_SLL:  res_c = data1 << shamt;
         OP_SRL:  res_c = data1 >> shamt;
         OP_SLT:  res_c = {31'd0, lt_s};
         OP_BEQ:  res_c = {31'd0, data1 == opb};
         OP_BNE:  res_c = {31'd0, data1 != opb};
         OP_SRA:  res_c = $signed(data1) >>> shamt;
         default: begin res_c = 32'd0; ovf_c = 1'b0; end
      endcase
   end

   generate
      if (REG_OUT) begin : g_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               result   <= 32'd0;
               zero     <= 1'b1;
               overflow <= 1'b0;
            end else begin
               result   <= res_c;
               zero     <= (res_c == 32'd0);
               overflow <= ovf_c;
            end
         end
      end else begin : g_comb
         // Clock and reset are intentionally inert in the combinational build.
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign result   = res_c;
         assign zero     = (res_c == 32'd0);
         assign overflow = ovf_c;
      end
   endgenerate

endmodule

// File: tb/tb_alu.sv
// Bench for alu: drives a combinational and a registered instance with identical
// stimulus and checks both against expected {zero, overflow, result} from a queue.
module tb_alu;

   logic        clk;
   logic        rst;
   logic        alu_src;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [31:0] imm;
   logic [3:0]  alu_ctrl;
   logic [31:0] c_result, r_result;
   logic        c_zero, r_zero;
   logic        c_ovf, r_ovf;

   logic [33:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   alu #(.REG_OUT(1'b0)) u_comb (
      .clk(clk), .rst(rst), .aluSrc(alu_src), .data1(data1), .data2(data2), .imm(imm),
      .aluCtrl(alu_ctrl), .result(c_result), .zero(c_zero), .overflow(c_ovf)
   );

   alu #(.REG_OUT(1'b1)) u_reg (
      .clk(clk), .rst(rst), .aluSrc(alu_src), .data1(data1), .data2(data2), .imm(imm),
      .aluCtrl(alu_ctrl), .result(r_result), .zero(r_zero), .overflow(r_ovf)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model, written independently of the RTL structure
   function automatic logic [33:0] model(input logic [3:0] op, input logic src,
                                         input logic [31:0] a, input logic [31:0] d2,
                                         input logic [31:0] im);
      logic [31:0] b;
      logic [63:0] w;
      logic [31:0] r;
      logic        o;
      b = src ? im : d2;
      r = 32'd0;
      o = 1'b0;
      case (op)
         4'd0:  begin w = {32'd0, a} + {32'd0, b}; r = w[31:0]; o = w[32]; end
         4'd1:  r = a ^ b;
         4'd2:  begin r = a - b; o = (a < b); end
         4'd3:  r = (a < b) ? 32'd1 : 32'd0;
         4'd4:  r = a & b;
         4'd5:  r = a | b;
         4'd6:  r = a << b[4:0];
         4'd7:  r = a >> b[4:0];
         4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:  r = (a == b) ? 32'd1 : 32'd0;
         4'd10: r = (a != b) ? 32'd1 : 32'd0;
         4'd11: r = 32'($signed(a) >>> b[4:0]);
         default: r = 32'd0;
      endcase
      return {(r == 32'd0), o, r};
   endfunction

   // driver: set inputs at negedge and push the stated expectation
   task automatic drive(input logic [3:0] op, input logic src, input logic [31:0] a,
                        input logic [31:0] d2, input logic [31:0] im,
                        input logic [31:0] exp_r, input logic exp_o);
      @(negedge clk);
      alu_ctrl = op; alu_src = src; data1 = a; data2 = d2; imm = im;
      exp_q.push_back({(exp_r == 32'd0), exp_o, exp_r});
   endtask

   task automatic drive_rand();
      logic [3:0]  op;
      logic        src;
      logic [31:0] a, d2, im;
      op = 4'($urandom_range(0, 15));
      src = 1'($urandom_range(0, 1));
      a = $urandom(); d2 = $urandom(); im = $urandom();
      if ($urandom_range(0, 3) == 0) d2 = a;
      if ($urandom_range(0, 3) == 0) im = a;
      @(negedge clk);
      alu_ctrl = op; alu_src = src; data1 = a; data2 = d2; imm = im;
      exp_q.push_back(model(op, src, a, d2, im));
   endtask

   // scoreboard: after the edge, both instances must show the oldest expectation
   task automatic check(input string tag);
      logic [33:0] exp_v;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty", tag);
         return;
      end
      exp_v = exp_q.pop_front();
      checks++;
      assert ({c_zero, c_ovf, c_result} === exp_v) else begin
         errors++;
         $error("FAIL %s comb observed=%h expected=%h", tag, {c_zero, c_ovf, c_result}, exp_v);
      end
      checks++;
      assert ({r_zero, r_ovf, r_result} === exp_v) else begin
         errors++;
         $error("FAIL %s reg observed=%h expected=%h", tag, {r_zero, r_ovf, r_result}, exp_v);
      end
   endtask

   task automatic check_reset(input string tag);
      @(posedge clk);
      #1;
      checks++;
      assert ({r_zero, r_ovf, r_result} === {1'b1, 1'b0, 32'd0}) else begin
         errors++;
         $error("FAIL %s reg observed=%h expected=%h", tag, {r_zero, r_ovf, r_result},
                {1'b1, 1'b0, 32'd0});
      end
   endtask

   initial begin
      rst = 1'b1;
      alu_src = 1'b0; data1 = 32'd3; data2 = 32'd5; imm = 32'd0; alu_ctrl = 4'd0;
      check_reset("reset");
      // comb instance ignores reset and already shows 3+5
      checks++;
      assert ({c_zero, c_ovf, c_result} === {1'b0, 1'b0, 32'd8}) else begin
         errors++;
         $error("FAIL comb_in_reset observed=%h expected=%h", {c_zero, c_ovf, c_result},
                {1'b0, 1'b0, 32'd8});
      end
      @(negedge clk);
      rst = 1'b0;

      drive(4'b0000, 1'b0, 32'd3, 32'd5, 32'hDEAD_BEEF, 32'd8, 1'b0);               check("add_reg");
      drive(4'b0000, 1'b1, 32'd7, 32'h1234_5678, 32'd9, 32'd16, 1'b0);              check("add_imm");
      drive(4'b0000, 1'b0, 32'hFFAA_123E, 32'hDD11_11B1, 32'd0, 32'hDCBB_23EF, 1'b1); check("add_carry");
      drive(4'b0010, 1'b0, 32'd15, 32'd5, 32'd0, 32'd10, 1'b0);                     check("sub_15_5");
      drive(4'b0010, 1'b1, 32'h1E, 32'hFFFF_FFFF, 32'h0A, 32'h14, 1'b0);            check("sub_imm");
      drive(4'b0010, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0);                       check("sub_zero");
      drive(4'b0010, 1'b0, 32'd1, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b1);               check("sub_borrow");
      drive(4'b0100, 1'b0, 32'hF0F0_F0F1, 32'h0F0F_0F0F, 32'd0, 32'h1, 1'b0);       check("and");
      drive(4'b0101, 1'b0, 32'hF0F0_F0F1, 32'h0F0F_0F0F, 32'd0, 32'hFFFF_FFFF, 1'b0); check("or");
      drive(4'b0001, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'hF0F0_F0F0, 1'b0); check("xor");
      drive(4'b0110, 1'b0, 32'd1, 32'd3, 32'd0, 32'd8, 1'b0);                       check("sll");
      drive(4'b0110, 1'b1, 32'd1, 32'd0, 32'hFFFF_FFE3, 32'd8, 1'b0);               check("sll_b_hi_ignored");
      drive(4'b0111, 1'b0, 32'd8, 32'd2, 32'd0, 32'd2, 1'b0);                       check("srl");
      drive(4'b0111, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'h0800_0000, 1'b0);       check("srl_zero_fill");
      drive(4'b1011, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000, 1'b0);       check("sra");
      drive(4'b1000, 1'b0, 32'd3, 32'd5, 32'd0, 32'd1, 1'b0);                       check("slt_3_5");
      drive(4'b1000, 1'b0, 32'd5, 32'd3, 32'd0, 32'd0, 1'b0);                       check("slt_5_3");
      drive(4'b1000, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b0);               check("slt_neg");
      drive(4'b0011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);               check("sltu_neg");
      drive(4'b0011, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0);               check("sltu_lt");
      drive(4'b1001, 1'b0, 32'd10, 32'd10, 32'd0, 32'd1, 1'b0);                     check("beq_eq");
      drive(4'b1001, 1'b0, 32'd10, 32'd20, 32'd0, 32'd0, 1'b0);                     check("beq_ne");
      drive(4'b1010, 1'b0, 32'd10, 32'd20, 32'd0, 32'd1, 1'b0);                     check("bne_ne");
      drive(4'b1010, 1'b0, 32'd10, 32'd10, 32'd0, 32'd0, 1'b0);                     check("bne_eq");
      drive(4'b1111, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);       check("rsvd_1111");
      drive(4'b1100, 1'b1, 32'h1234_5678, 32'd0, 32'h1, 32'd0, 1'b0);               check("rsvd_1100");

      // mid-stream reset, then the first edge with rst low captures live inputs
      @(negedge clk);
      rst = 1'b1;
      alu_ctrl = 4'b0000; alu_src = 1'b0; data1 = 32'd100; data2 = 32'd23;
      check_reset("reset_mid");
      drive(4'b0000, 1'b0, 32'd3, 32'd5, 32'd0, 32'd8, 1'b0);
      rst = 1'b0;
      check("after_reset");

      for (int i = 0; i < 300; i++) begin
         drive_rand();
         check("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
